// File: rtl/jamma_pkg.sv
// rtl/jamma_pkg.sv - shared defaults, scan states and idle level for the JAMMA input scanner
package jamma_pkg;

  localparam int NUM_CH_DEF   = 2;
  localparam int WIDTH_DEF    = 8;
  localparam int SETTLE_DEF   = 2;
  localparam int DEBOUNCE_DEF = 3;

  typedef enum logic {
    ST_SETTLE = 1'b0,
    ST_SAMPLE = 1'b1
  } scan_state_t;

  // JAMMA inputs are active-low, so an idle (released) bit reads as one.
  localparam logic IDLE_LVL = 1'b1;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/jamma_debounce.sv
// rtl/jamma_debounce.sv - per-bit history debouncer for one player bank
module jamma_debounce
  import jamma_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int DEBOUNCE = DEBOUNCE_DEF
) (
  input  logic             pclk,
  input  logic             reset_n,
  input  logic             shift,
  input  logic             clear,
  input  logic [WIDTH-1:0] sample,
  output logic [WIDTH-1:0] bank
);

  generate
    if (DEBOUNCE == 1) begin : g_direct
      always_ff @(posedge pclk) begin
        if (!reset_n || clear) begin
          bank <= {WIDTH{IDLE_LVL}};
        end else if (shift) begin
          bank <= sample;
        end
      end
    end else begin : g_hist
      // The incoming sample is the newest history entry, so only DEBOUNCE-1 older ones are stored.
      localparam int HD = DEBOUNCE - 1;

      logic [HD-1:0][WIDTH-1:0] hist;
      logic [WIDTH-1:0]         all_hi;
      logic [WIDTH-1:0]         all_lo;

      always_comb begin
        all_hi = sample;
        all_lo = ~sample;
        for (int i = 0; i < HD; i++) begin
          all_hi = all_hi & hist[i];
          all_lo = all_lo & ~hist[i];
        end
      end

      always_ff @(posedge pclk) begin
        if (!reset_n || clear) begin
          hist <= {HD{{WIDTH{IDLE_LVL}}}};
          bank <= {WIDTH{IDLE_LVL}};
        end else if (shift) begin
          hist[0] <= sample;
          for (int i = 1; i < HD; i++) begin
            hist[i] <= hist[i-1];
          end
          bank <= (bank | all_hi) & ~all_lo;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/jamma_input_scanner.sv
// rtl/jamma_input_scanner.sv - time-multiplexed JAMMA bank scanner with settle delay and debounce
module jamma_input_scanner
  import jamma_pkg::*;
#(
  parameter int NUM_CH   = NUM_CH_DEF,
  parameter int WIDTH    = WIDTH_DEF,
  parameter int SETTLE   = SETTLE_DEF,
  parameter int DEBOUNCE = DEBOUNCE_DEF,
  localparam int SEL_W   = sel_width(NUM_CH)
) (
  input  logic                    pclk,
  input  logic                    reset_n,
  input  logic                    scan_en,
  input  logic                    mux_en,
  input  logic [WIDTH-1:0]        jjoy,
  output logic [SEL_W-1:0]        jselect,
  output logic [NUM_CH*WIDTH-1:0] joy_out,
  output logic                    scan_done
);

  localparam int               CNT_W    = $clog2(SETTLE + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
  localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(NUM_CH - 1);

  scan_state_t      state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [SEL_W-1:0] ch_q, ch_d;
  logic             single_q, single_d;
  logic             done_q, done_d;
  logic             multi;
  logic             sample_now;

  // A single-bank build can never scan, whatever mux_en says.
  assign multi      = mux_en && (NUM_CH > 1);
  assign sample_now = scan_en && (state_q == ST_SAMPLE);

  always_ff @(posedge pclk) begin
    if (!reset_n) begin
      state_q  <= ST_SETTLE;
      count_q  <= '0;
      ch_q     <= '0;
      single_q <= 1'b0;
      done_q   <= 1'b0;
    end else if (scan_en) begin
      state_q  <= state_d;
      count_q  <= count_d;
      ch_q     <= ch_d;
      single_q <= single_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    ch_d     = ch_q;
    single_d = single_q;
    done_d   = 1'b0;
    case (state_q)
      ST_SETTLE: begin
        count_d = count_q + 1'b1;
        if (count_q == CNT_LAST) begin
          state_d = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        // Mode is only looked at here, so a slot in progress always completes.
        count_d  = '0;
        state_d  = ST_SETTLE;
        single_d = !multi;
        if (multi) begin
          ch_d   = (ch_q == LAST_CH) ? '0 : ch_q + 1'b1;
          done_d = (ch_q == LAST_CH);
        end else begin
          ch_d   = '0;
          done_d = (ch_q == '0);
        end
      end
    endcase
  end

  assign jselect   = ch_q;
  // A pulse caught by a freeze is held back and shown once scanning resumes.
  assign scan_done = done_q && scan_en;

  generate
    for (genvar c = 0; c < NUM_CH; c++) begin : g_bank
      jamma_debounce #(
        .WIDTH    (WIDTH),
        .DEBOUNCE (DEBOUNCE)
      ) u_debounce (
        .pclk    (pclk),
        .reset_n (reset_n),
        .shift   (sample_now && (ch_q == SEL_W'(c))),
        .clear   (scan_en && single_q && (c != 0)),
        .sample  (jjoy),
        .bank    (joy_out[c*WIDTH +: WIDTH])
      );
    end
  endgenerate

endmodule

// File: tb/tb_jamma_input_scanner.sv
// tb/tb_jamma_input_scanner.sv - directed scoreboard bench for jamma_input_scanner (2 banks x 8 bits)
module tb_jamma_input_scanner;

  typedef struct {
    logic [0:0]  sel;
    logic [15:0] joy;
    logic        done;
  } exp_t;

  logic        pclk = 1'b0;
  logic        reset_n;
  logic        scan_en;
  logic        mux_en;
  logic [7:0]  jjoy;
  logic [0:0]  jselect;
  logic [15:0] joy_out;
  logic        scan_done;

  logic [7:0]  b0;
  logic [7:0]  b1;
  exp_t        sb[$];
  int          e;
  int          checks = 0;
  int          errors = 0;

  always #5 pclk = ~pclk;

  // External bus mux: the selected player's bank appears on jjoy.
  assign jjoy = (jselect == 1'b0) ? b0 : b1;

  jamma_input_scanner #(
    .NUM_CH   (2),
    .WIDTH    (8),
    .SETTLE   (2),
    .DEBOUNCE (3)
  ) dut (
    .pclk      (pclk),
    .reset_n   (reset_n),
    .scan_en   (scan_en),
    .mux_en    (mux_en),
    .jjoy      (jjoy),
    .jselect   (jselect),
    .joy_out   (joy_out),
    .scan_done (scan_done)
  );

  // Expected view after enabled cycle n since reset release.
  function automatic logic f_sel(input int n);
    if (n >= 78) return 1'b1;
    if (n >= 57) return 1'b0;
    return (n % 6) >= 3;
  endfunction

  function automatic logic f_done(input int n);
    if (n >= 78) return 1'b0;
    if (n >= 57) return ((n - 57) % 3) == 0;
    return (n > 0) && ((n % 6) == 0);
  endfunction

  function automatic logic [15:0] f_joy(input int n);
    if (n < 15) return 16'hFFFF;
    if (n < 18) return 16'hFFFE;
    if (n < 33) return 16'h7FFE;
    if (n < 58) return 16'h7FFF;
    if (n < 66) return 16'hFFFF;
    return 16'hFF5A;
  endfunction

  function automatic logic [7:0] f_b0(input int n);
    if (n < 18) return 8'hFE;
    if (n < 36) return 8'hFF;
    if (n < 48) return 8'hFE;
    if (n < 57) return 8'hFF;
    return 8'h5A;
  endfunction

  task automatic push_check(input string tag, input logic [0:0] sel, input logic [15:0] joy,
                            input logic done);
    exp_t x;
    exp_t got;
    x.sel  = sel;
    x.joy  = joy;
    x.done = done;
    sb.push_back(x);
    @(posedge pclk);
    #1;
    got = sb.pop_front();
    checks++;
    assert (jselect === got.sel) else begin
      errors++;
      $error("FAIL %s jselect obs=%0h exp=%0h", tag, jselect, got.sel);
    end
    checks++;
    assert (joy_out === got.joy) else begin
      errors++;
      $error("FAIL %s joy_out obs=%04h exp=%04h", tag, joy_out, got.joy);
    end
    checks++;
    assert (scan_done === got.done) else begin
      errors++;
      $error("FAIL %s scan_done obs=%0b exp=%0b", tag, scan_done, got.done);
    end
  endtask

  task automatic step(input string tag, input logic en);
    int n;
    scan_en = en;
    mux_en  = (e < 55) || (e >= 76);
    b0      = f_b0(e);
    b1      = en ? 8'h7F : 8'h00;
    n       = en ? e + 1 : e;
    push_check(tag, f_sel(n), f_joy(n), en ? f_done(n) : 1'b0);
    if (en) e++;
  endtask

  initial begin
    reset_n = 1'b0;
    scan_en = 1'b1;
    mux_en  = 1'b1;
    b0      = 8'h00;
    b1      = 8'h00;
    e       = 0;

    repeat (5) push_check("reset", 1'b0, 16'hFFFF, 1'b0);
    reset_n = 1'b1;

    repeat (40) step("scan", 1'b1);
    repeat (10) step("freeze", 1'b0);
    repeat (15) step("resume", 1'b1);
    repeat (21) step("single", 1'b1);
    repeat (4)  step("remux", 1'b1);

    reset_n = 1'b0;
    push_check("reset_mid", 1'b0, 16'hFFFF, 1'b0);
    reset_n = 1'b1;
    push_check("post_reset", 1'b0, 16'hFFFF, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
